// File: rtl/freq_decimator.sv
// freq_decimator: per-channel I/Q integrator over 2^DEC_LOG2 samples using a read-modify-write RAM
// pipeline and a first-word-fall-through output FIFO. Define FREQ_DECIM_MEAN_EN for rounded 32-bit means.
module freq_decimator #(
    parameter  int unsigned NCH        = 128,
    parameter  int unsigned DEC_LOG2   = 4,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IDX_W      = $clog2(NCH),
    localparam int unsigned ACC_W      = 32 + DEC_LOG2,
`ifdef FREQ_DECIM_MEAN_EN
    localparam int unsigned OUT_W      = 32
`else
    localparam int unsigned OUT_W      = ACC_W
`endif
) (
    input  logic                   dev_clk,
    input  logic                   reset_n,
    input  logic [79:0]            data_in,
    input  logic [IDX_W-1:0]       index_in,
    input  logic                   valid_in,
    input  logic                   clear,
    output logic [16+2*OUT_W-1:0]  data_out,
    output logic [IDX_W-1:0]       index_out,
    output logic                   valid_out,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   overflow
);
    localparam int unsigned CNT_W  = DEC_LOG2;
    localparam int unsigned WORD_W = CNT_W + 2 * ACC_W;
    localparam int unsigned RES_W  = 16 + 2 * OUT_W;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] init_ptr;

    // Init sweep controller: zeroes every RAM word once after reset or clear
    always_ff @(posedge dev_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_ptr <= '0;
            busy     <= 1'b1;
        end else if (clear) begin
            state    <= ST_INIT;
            init_ptr <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    init_ptr <= init_ptr + IDX_W'(1);
                    if (init_ptr == IDX_W'(NCH - 1)) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: ;
                default: ;
            endcase
        end
    end

    logic               s0_valid;
    logic [IDX_W-1:0]   s0_idx;
    logic [15:0]        s0_tag;
    logic signed [31:0] s0_q, s0_i;

    always_ff @(posedge dev_clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid <= 1'b0;
            s0_idx   <= '0;
            s0_tag   <= '0;
            s0_q     <= '0;
            s0_i     <= '0;
        end else begin
            s0_valid <= valid_in && !busy && !clear;
            if (valid_in && !busy) begin
                s0_idx <= index_in;
                s0_tag <= data_in[79:64];
                s0_q   <= data_in[63:32];
                s0_i   <= data_in[31:0];
            end
        end
    end

    logic               s1_valid;
    logic [IDX_W-1:0]   s1_idx;
    logic [15:0]        s1_tag;
    logic signed [31:0] s1_q, s1_i;

    always_ff @(posedge dev_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_tag   <= '0;
            s1_q     <= '0;
            s1_i     <= '0;
        end else begin
            s1_valid <= s0_valid && !clear;
            s1_idx   <= s0_idx;
            s1_tag   <= s0_tag;
            s1_q     <= s0_q;
            s1_i     <= s0_i;
        end
    end

    logic [WORD_W-1:0] ram [NCH];
    logic [WORD_W-1:0] s1_word;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [WORD_W-1:0] ram_wdata;

    // Read returns old data on a same-address write, so the write data is bypassed into S1
    always_ff @(posedge dev_clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
        s1_word <= (ram_we && (ram_waddr == s0_idx)) ? ram_wdata : ram[s0_idx];
    end

    logic [CNT_W-1:0]        s1_cnt;
    logic signed [ACC_W-1:0] sum_q, sum_i;
    logic                    win_done;

    always_comb begin
        s1_cnt   = s1_word[WORD_W-1 -: CNT_W];
        sum_q    = $signed(s1_word[2*ACC_W-1 -: ACC_W]) + ACC_W'(s1_q);
        sum_i    = $signed(s1_word[ACC_W-1:0]) + ACC_W'(s1_i);
        win_done = (s1_cnt == {CNT_W{1'b1}});
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s1_idx;
        ram_wdata = win_done ? '0 : {s1_cnt + CNT_W'(1), sum_q, sum_i};
        if (!clear) begin
            if (busy) begin
                ram_we    = 1'b1;
                ram_waddr = init_ptr;
                ram_wdata = '0;
            end else if (s1_valid) begin
                ram_we = 1'b1;
            end
        end
    end

    logic                    s2_push;
    logic [IDX_W-1:0]        s2_idx;
    logic [15:0]             s2_tag;
    logic signed [ACC_W-1:0] s2_q, s2_i;

    always_ff @(posedge dev_clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_push <= 1'b0;
            s2_idx  <= '0;
            s2_tag  <= '0;
            s2_q    <= '0;
            s2_i    <= '0;
        end else begin
            s2_push <= s1_valid && win_done && !clear;
            if (s1_valid && win_done) begin
                s2_idx <= s1_idx;
                s2_tag <= s1_tag;
                s2_q   <= sum_q;
                s2_i   <= sum_i;
            end
        end
    end

    logic             push_req;
    logic [RES_W-1:0] push_data;
    logic [IDX_W-1:0] push_idx;

`ifdef FREQ_DECIM_MEAN_EN
    localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(2 ** (DEC_LOG2 - 1));

    logic signed [ACC_W:0]   rnd_q, rnd_i;
    logic                    s3_push;
    logic [IDX_W-1:0]        s3_idx;
    logic [15:0]             s3_tag;
    logic signed [OUT_W-1:0] s3_q, s3_i;

    // Round half toward +inf, then divide by the window length
    always_comb begin
        rnd_q = (ACC_W + 1)'(s2_q) + RND;
        rnd_i = (ACC_W + 1)'(s2_i) + RND;
    end

    always_ff @(posedge dev_clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_push <= 1'b0;
            s3_idx  <= '0;
            s3_tag  <= '0;
            s3_q    <= '0;
            s3_i    <= '0;
        end else begin
            s3_push <= s2_push && !clear;
            if (s2_push) begin
                s3_idx <= s2_idx;
                s3_tag <= s2_tag;
                s3_q   <= OUT_W'(rnd_q >>> DEC_LOG2);
                s3_i   <= OUT_W'(rnd_i >>> DEC_LOG2);
            end
        end
    end

    always_comb begin
        push_req  = s3_push;
        push_data = {s3_tag, s3_q, s3_i};
        push_idx  = s3_idx;
    end
`else
    always_comb begin
        push_req  = s2_push;
        push_data = {s2_tag, s2_q, s2_i};
        push_idx  = s2_idx;
    end
`endif

    logic [RES_W-1:0]  fifo_data [FIFO_DEPTH];
    logic [IDX_W-1:0]  fifo_idx  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [FCNT_W-1:0] fcnt, fcnt_nxt, remain;
    logic              pop, accept, drop;
    logic [RES_W-1:0]  head_data;
    logic [IDX_W-1:0]  head_idx;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    always_comb begin
        pop        = valid_out && out_ready;
        accept     = push_req && ((fcnt != FCNT_W'(FIFO_DEPTH)) || pop);
        drop       = push_req && !accept;
        remain     = fcnt - FCNT_W'(pop);
        fcnt_nxt   = remain + FCNT_W'(accept);
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        if (remain == '0) begin
            head_data = push_data;
            head_idx  = push_idx;
        end else begin
            head_data = fifo_data[rd_ptr_nxt];
            head_idx  = fifo_idx[rd_ptr_nxt];
        end
    end

    always_ff @(posedge dev_clk) begin
        if (accept && !clear) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_idx[wr_ptr]  <= push_idx;
        end
    end

    // Head of the FIFO is mirrored into the output registers
    always_ff @(posedge dev_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fcnt      <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            index_out <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fcnt      <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_nxt;
            fcnt      <= fcnt_nxt;
            valid_out <= (fcnt_nxt != '0);
            if (fcnt_nxt != '0) begin
                data_out  <= head_data;
                index_out <= head_idx;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freq_decimator.sv
// Scoreboard bench for freq_decimator (DEC_LOG2 = 2): reference model of per-index window sums
// feeds an expected-result queue that a monitor compares on every output transfer.
module tb_freq_decimator;
    localparam int unsigned NCH   = 128;
    localparam int unsigned D     = 2;
    localparam int unsigned WIN   = 1 << D;
    localparam int unsigned ACC_W = 32 + D;
`ifdef FREQ_DECIM_MEAN_EN
    localparam int unsigned OUT_W = 32;
    localparam int unsigned LAT   = 4;
`else
    localparam int unsigned OUT_W = ACC_W;
    localparam int unsigned LAT   = 3;
`endif
    localparam int unsigned RES_W = 16 + 2 * OUT_W;

    logic             dev_clk = 1'b0;
    logic             reset_n;
    logic [79:0]      data_in;
    logic [6:0]       index_in;
    logic             valid_in;
    logic             clear;
    logic [RES_W-1:0] data_out;
    logic [6:0]       index_out;
    logic             valid_out;
    logic             out_ready;
    logic             busy;
    logic             overflow;

    freq_decimator #(.NCH(NCH), .DEC_LOG2(D), .FIFO_DEPTH(4)) dut (
        .dev_clk   (dev_clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .index_in  (index_in),
        .valid_in  (valid_in),
        .clear     (clear),
        .data_out  (data_out),
        .index_out (index_out),
        .valid_out (valid_out),
        .out_ready (out_ready),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 dev_clk = ~dev_clk;

    typedef struct {
        logic [RES_W-1:0] data;
        logic [6:0]       idx;
    } exp_t;

    exp_t   exp_q[$];
    int     checks;
    int     errors;
    int     pops;
    longint m_i [NCH];
    longint m_q [NCH];
    int     m_cnt [NCH];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [RES_W-1:0] pack(input logic [15:0] tag, input longint q, input longint i);
        return {tag, OUT_W'(q), OUT_W'(i)};
    endfunction

    function automatic longint result(input longint sum);
`ifdef FREQ_DECIM_MEAN_EN
        return (sum + longint'(WIN / 2)) >>> D;
`else
        return sum;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < int'(NCH); k++) begin
            m_i[k] = 0;
            m_q[k] = 0;
            m_cnt[k] = 0;
        end
    endtask

    // Window bookkeeping from the behavioural rules; 'keep' is cleared for results the FIFO must drop
    task automatic model(input int idx, input longint i, input longint q, input logic [15:0] tag, input bit keep);
        exp_t e;
        m_i[idx] += i;
        m_q[idx] += q;
        m_cnt[idx]++;
        if (m_cnt[idx] == int'(WIN)) begin
            e.data = pack(tag, result(m_q[idx]), result(m_i[idx]));
            e.idx  = 7'(idx);
            if (keep) exp_q.push_back(e);
            m_i[idx] = 0;
            m_q[idx] = 0;
            m_cnt[idx] = 0;
        end
    endtask

    // Called at posedge+1; the sample is captured by the next posedge
    task automatic send(input int idx, input logic signed [31:0] i, input logic signed [31:0] q,
                        input logic [15:0] tag, input bit keep = 1'b1);
        data_in  = {tag, q, i};
        index_in = 7'(idx);
        valid_in = 1'b1;
        model(idx, longint'(i), longint'(q), tag, keep);
        @(posedge dev_clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge dev_clk);
            #1;
        end
    endtask

    task automatic lat_check(input logic [RES_W-1:0] ed, input logic [6:0] ei);
        for (int j = 0; j <= int'(LAT); j++) begin
            @(negedge dev_clk);
            chk("lat_valid", 128'(valid_out), 128'(j == int'(LAT)));
        end
        chk("lat_data", data_out, ed);
        chk("lat_index", index_out, ei);
        @(posedge dev_clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            idle(1);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge dev_clk);
            if (reset_n && valid_out && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got index %0d data %0h, required no output", index_out, data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_index", index_out, e.idx);
                    chk("out_data", data_out, e.data);
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        bit saw_valid;
        checks = 0;
        errors = 0;
        pops = 0;
        reset_n = 1'b0;
        data_in = '0;
        index_in = '0;
        valid_in = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        model_reset();
        fork
            monitor();
        join_none

        repeat (3) @(negedge dev_clk);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_index", index_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 1);

        // Samples held on the input throughout the init sweep must be ignored
        data_in = {16'hdead, 32'sd77, 32'sd1000};
        index_in = 7'd5;
        valid_in = 1'b1;
        reset_n = 1'b1;
        n = 0;
        saw_valid = 1'b0;
        while (busy && n < 1000) begin
            n++;
            if (valid_out) saw_valid = 1'b1;
            @(negedge dev_clk);
        end
        valid_in = 1'b0;
        chk("busy_cycles", n, 128);
        chk("busy_low", busy, 0);
        chk("init_no_valid", saw_valid, 0);
        @(posedge dev_clk);
        #1;

        // Non-consecutive window on index 5
        for (int k = 0; k < 4; k++) begin
            send(5, 32'(k + 1), -32'(k + 1), 16'h10 + 16'(k));
            if (k < 3) idle(2);
        end
`ifdef FREQ_DECIM_MEAN_EN
        lat_check(pack(16'h13, -2, 3), 7'd5);
`else
        lat_check(pack(16'h13, -10, 10), 7'd5);
`endif
        idle(4);

        // Same window back to back (forwarding path)
        for (int k = 0; k < 4; k++) send(5, 32'(k + 1), -32'(k + 1), 16'h10 + 16'(k));
`ifdef FREQ_DECIM_MEAN_EN
        lat_check(pack(16'h13, -2, 3), 7'd5);
`else
        lat_check(pack(16'h13, -10, 10), 7'd5);
`endif
        idle(4);

        // Round-robin passes over every index
        p0 = pops;
        for (int p = 0; p < 4; p++)
            for (int idx = 0; idx < int'(NCH); idx++)
                send(idx, 32'(idx), 32'sd0, 16'(p * 128 + idx));
        drain();
        chk("rr_results", pops - p0, 128);
        chk("rr_overflow", overflow, 0);

        // Random samples on a few indices, full output rate
        for (int c = 0; c < 300; c++) begin
            if (($urandom % 10) < 7) send(int'($urandom % 8), $urandom, $urandom, 16'($urandom));
            else idle(1);
        end
        drain();

        // Random backpressure with sparse input, never enough to fill the FIFO
        for (int c = 0; c < 200; c++) begin
            out_ready = 1'($urandom) | 1'(c % 2);
            if ((c % 4) == 0) send(int'($urandom % 8), $urandom, $urandom, 16'($urandom));
            else idle(1);
        end
        out_ready = 1'b1;
        drain();
        chk("rand_overflow", overflow, 0);

        // Six windows complete with no reader: four held, two dropped
        out_ready = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 6; k++)
                send(40 + k, 32'(7 * k + r), -32'(r), 16'(16'h400 + 16 * k + r), k < 4);
        idle(6);
        chk("ovf_flag", overflow, 1);
        chk("ovf_valid", valid_out, 1);
        for (int j = 0; j < 3; j++) begin
            @(negedge dev_clk);
            chk("hold_index", index_out, exp_q[0].idx);
            chk("hold_data", data_out, exp_q[0].data);
        end
        @(posedge dev_clk);
        #1;
        p0 = pops;
        out_ready = 1'b1;
        drain();
        idle(3);
        @(negedge dev_clk);
        chk("ovf_drained", pops - p0, 4);
        chk("ovf_empty", valid_out, 0);
        @(posedge dev_clk);
        #1;

        // Partial window abandoned by a clear pulse
        send(9, 32'sd100, 32'sd0, 16'h0900);
        send(9, 32'sd100, 32'sd0, 16'h0901);
        clear = 1'b1;
        model_reset();
        exp_q.delete();
        @(posedge dev_clk);
        #1;
        clear = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(posedge dev_clk);
            #1;
        end
        chk("clr_busy_cycles", n, 128);
        chk("clr_valid", valid_out, 0);
        chk("clr_overflow", overflow, 0);
        for (int k = 0; k < 4; k++) send(9, 32'sd1, 32'sd0, 16'h0910 + 16'(k));
`ifdef FREQ_DECIM_MEAN_EN
        lat_check(pack(16'h0913, 0, 1), 7'd9);
`else
        lat_check(pack(16'h0913, 0, 4), 7'd9);
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
